// File: rtl/fb_rect_pkg.sv
// rtl/fb_rect_pkg.sv - register offsets, FSM encoding, defaults and clipping helper
package fb_rect_pkg;

  localparam int DEF_HOR_RES  = 320;
  localparam int DEF_VERT_RES = 240;

  localparam logic [2:0] OFF_X_LO = 3'd0;
  localparam logic [2:0] OFF_X_HI = 3'd1;
  localparam logic [2:0] OFF_Y    = 3'd2;
  localparam logic [2:0] OFF_W_LO = 3'd3;
  localparam logic [2:0] OFF_W_HI = 3'd4;
  localparam logic [2:0] OFF_H    = 3'd5;
  localparam logic [2:0] OFF_MODE = 3'd6;
  localparam logic [2:0] OFF_GO   = 3'd7;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_FILL  = 3'd2;
  localparam logic [2:0] ST_RD    = 3'd3;
  localparam logic [2:0] ST_WR    = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  typedef struct packed {
    logic [8:0] x;
    logic [7:0] y;
    logic [8:0] w;
    logic [7:0] h;
    logic [1:0] mode;
  } rect_regs_t;

  // Length of a span starting at pos that still fits inside res.
  function automatic logic [9:0] clip_extent(input logic [9:0] pos,
                                             input logic [9:0] len,
                                             input logic [9:0] res);
    if (pos >= res)
      return 10'd0;
    else if (len < res - pos)
      return len;
    else
      return res - pos;
  endfunction

endpackage

// File: rtl/fb_rect_writer_if.sv
// rtl/fb_rect_writer_if.sv - processor bus and frame-buffer port A signal bundle
interface fb_rect_writer_if;
  logic [7:0]  BUS_ADDR;
  logic [7:0]  BUS_DATA_IN;
  logic        BUS_WE;
  logic [7:0]  BUS_DATA_OUT;
  logic        BUS_DATA_OE;
  logic [16:0] A_ADDR;
  logic        A_DATA_IN;
  logic        A_DATA_OUT;
  logic        A_WE;
  logic        BUSY;
  logic        DONE_IRQ;

  modport slave (
    input  BUS_ADDR, BUS_DATA_IN, BUS_WE, A_DATA_OUT,
    output BUS_DATA_OUT, BUS_DATA_OE, A_ADDR, A_DATA_IN, A_WE, BUSY, DONE_IRQ
  );

  modport master (
    output BUS_ADDR, BUS_DATA_IN, BUS_WE, A_DATA_OUT,
    input  BUS_DATA_OUT, BUS_DATA_OE, A_ADDR, A_DATA_IN, A_WE, BUSY, DONE_IRQ
  );
endinterface

// File: rtl/rect_addr_gen.sv
// rtl/rect_addr_gen.sv - row-major x/y stepping over a clipped rectangle
module rect_addr_gen (
  input  logic        clk,
  input  logic        resetn,
  input  logic        load,
  input  logic        step,
  input  logic [8:0]  x0,
  input  logic [7:0]  y0,
  input  logic [9:0]  w,
  input  logic [9:0]  h,
  output logic [16:0] addr,
  output logic        last
);

  logic [8:0] x_start;
  logic [8:0] cx;
  logic [7:0] cy;
  logic [9:0] w_l;
  logic [9:0] col_rem;
  logic [9:0] row_rem;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      x_start <= '0;
      cx      <= '0;
      cy      <= '0;
      w_l     <= '0;
      col_rem <= '0;
      row_rem <= '0;
    end else if (load) begin
      x_start <= x0;
      cx      <= x0;
      cy      <= y0;
      w_l     <= w;
      col_rem <= w - 10'd1;
      row_rem <= h - 10'd1;
    end else if (step) begin
      if (col_rem == 10'd0) begin
        cx      <= x_start;
        cy      <= cy + 8'd1;
        col_rem <= w_l - 10'd1;
        row_rem <= row_rem - 10'd1;
      end else begin
        cx      <= cx + 9'd1;
        col_rem <= col_rem - 10'd1;
      end
    end
  end

  assign addr = {cy, cx};
  assign last = (col_rem == 10'd0) && (row_rem == 10'd0);

endmodule

// File: rtl/fb_rect_writer.sv
// rtl/fb_rect_writer.sv - register-programmed rectangle fill / XOR writer for a 1-bpp frame buffer
module fb_rect_writer
  import fb_rect_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR = 8'hB0,
  parameter int         HOR_RES   = DEF_HOR_RES,
  parameter int         VERT_RES  = DEF_VERT_RES
) (
  input logic CLK,
  input logic RESET,
  fb_rect_writer_if.slave bus
);

  logic [7:0]  off;
  logic        hit;
  logic        wr_ok;
  logic        rd_hit;
  logic        busy;
  logic        blocked;
  logic        go_pending;
  logic [2:0]  state;
  logic [2:0]  state_nxt;
  rect_regs_t  regs;
  logic [9:0]  weff;
  logic [9:0]  heff;
  logic        load;
  logic        step;
  logic        last;
  logic [16:0] addr;
  logic [7:0]  rd_data;
  logic        rd_oe;

  assign off    = bus.BUS_ADDR - BASE_ADDR;
  assign hit    = (off[7:3] == 5'd0);
  assign busy   = state inside {ST_SETUP, ST_FILL, ST_RD, ST_WR};
  // The cycle between a GO write and SETUP is treated as busy for the bus so
  // the operation runs on the register values seen at the GO write.
  assign blocked = busy | go_pending;
  assign wr_ok   = hit & bus.BUS_WE & ~blocked;
  assign rd_hit  = hit & ~bus.BUS_WE & (off[2:0] == OFF_GO);

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      regs       <= '0;
      go_pending <= 1'b0;
      rd_data    <= '0;
      rd_oe      <= 1'b0;
    end else begin
      go_pending <= wr_ok && (off[2:0] == OFF_GO);
      rd_oe      <= rd_hit;
      rd_data    <= rd_hit ? {7'b0, busy} : 8'h00;
      if (wr_ok) begin
        case (off[2:0])
          OFF_X_LO: regs.x[7:0] <= bus.BUS_DATA_IN;
          OFF_X_HI: regs.x[8]   <= bus.BUS_DATA_IN[0];
          OFF_Y:    regs.y      <= bus.BUS_DATA_IN;
          OFF_W_LO: regs.w[7:0] <= bus.BUS_DATA_IN;
          OFF_W_HI: regs.w[8]   <= bus.BUS_DATA_IN[0];
          OFF_H:    regs.h      <= bus.BUS_DATA_IN;
          OFF_MODE: regs.mode   <= bus.BUS_DATA_IN[1:0];
          default:  ;
        endcase
      end
    end
  end

  assign weff = clip_extent({1'b0, regs.x}, {1'b0, regs.w}, 10'(HOR_RES));
  assign heff = clip_extent({2'b0, regs.y}, {2'b0, regs.h}, 10'(VERT_RES));

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (go_pending) state_nxt = ST_SETUP;
      ST_SETUP: begin
        if (weff == 10'd0 || heff == 10'd0)
          state_nxt = ST_DONE;
        else if (regs.mode[1])
          state_nxt = ST_RD;
        else
          state_nxt = ST_FILL;
      end
      ST_FILL:  if (last) state_nxt = ST_DONE;
      ST_RD:    state_nxt = ST_WR;
      ST_WR:    state_nxt = last ? ST_DONE : ST_RD;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  assign load = (state == ST_SETUP);
  assign step = (state == ST_FILL) || (state == ST_WR);

  rect_addr_gen u_addr_gen (
    .clk    (CLK),
    .resetn (RESET),
    .load   (load),
    .step   (step),
    .x0     (regs.x),
    .y0     (regs.y),
    .w      (weff),
    .h      (heff),
    .addr   (addr),
    .last   (last)
  );

  assign bus.A_ADDR       = addr;
  assign bus.A_WE         = step;
  assign bus.A_DATA_IN    = (state == ST_FILL) ? regs.mode[0] :
                            (state == ST_WR)   ? (bus.A_DATA_OUT ^ regs.mode[0]) : 1'b0;
  assign bus.BUSY         = busy;
  assign bus.DONE_IRQ     = (state == ST_DONE);
  assign bus.BUS_DATA_OUT = rd_data;
  assign bus.BUS_DATA_OE  = rd_oe;

endmodule

// File: tb/tb_fb_rect_writer.sv
// tb/tb_fb_rect_writer.sv - self-checking bench for fb_rect_writer with a frame-buffer model
module tb_fb_rect_writer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fb_rect_writer_if bif();

  fb_rect_writer #(.BASE_ADDR(8'hB0), .HOR_RES(320), .VERT_RES(240)) dut (
    .CLK   (clk),
    .RESET (rst_n),
    .bus   (bif.slave)
  );

  typedef struct {
    int unsigned addr;
    bit          data;
    int          cyc;
  } wr_rec_t;

  typedef struct {
    int x, y, w, h, mode;
    int n;
    int first_addr;
  } vec_t;

  wr_rec_t got_q[$];
  bit      mem[0:131071];
  bit      ref_mem[0:131071];
  int      cyc = 0;
  int      irq_total = 0;
  int      busy_total = 0;
  int      total = 0;
  int      bad = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bif.A_WE === 1'b1) mem[bif.A_ADDR] <= bif.A_DATA_IN;
    bif.A_DATA_OUT <= mem[bif.A_ADDR];
  end

  always @(negedge clk) begin
    if (bif.A_WE === 1'b1) got_q.push_back('{int'(bif.A_ADDR), bif.A_DATA_IN, cyc});
    if (bif.DONE_IRQ === 1'b1) irq_total++;
    if (bif.BUSY === 1'b1) busy_total++;
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic bus_wr(input logic [2:0] off, input logic [7:0] d);
    @(negedge clk);
    bif.BUS_ADDR = 8'hB0 + 8'(off);
    bif.BUS_DATA_IN = d;
    bif.BUS_WE = 1'b1;
    @(negedge clk);
    bif.BUS_WE = 1'b0;
    bif.BUS_ADDR = 8'h00;
  endtask

  task automatic bus_rd(input logic [2:0] off, output logic [7:0] d, output logic oe);
    @(negedge clk);
    bif.BUS_ADDR = 8'hB0 + 8'(off);
    bif.BUS_WE = 1'b0;
    @(negedge clk);
    bif.BUS_ADDR = 8'h00;
    d = bif.BUS_DATA_OUT;
    oe = bif.BUS_DATA_OE;
  endtask

  task automatic program_rect(input int x, input int y, input int w, input int h, input int mode);
    bus_wr(3'd0, x[7:0]);
    bus_wr(3'd1, {7'b0, x[8]});
    bus_wr(3'd2, y[7:0]);
    bus_wr(3'd3, w[7:0]);
    bus_wr(3'd4, {7'b0, w[8]});
    bus_wr(3'd5, h[7:0]);
    bus_wr(3'd6, mode[7:0]);
  endtask

  task automatic run_rect(input int x, input int y, input int w, input int h, input int mode,
                          input bit interfere, input string tag,
                          output int nw, output int first_addr);
    int weff, heff, base, irq0, busy0, go_cyc, n, exp_busy;
    bit c, xr;
    logic [7:0] d;
    logic oe;
    wr_rec_t exp_q[$];
    int unsigned a;

    program_rect(x, y, w, h, mode);
    base  = got_q.size();
    irq0  = irq_total;
    busy0 = busy_total;
    bus_wr(3'd7, 8'h00);
    go_cyc = cyc;
    if (interfere) begin
      repeat (3) @(negedge clk);
      bus_wr(3'd0, 8'd50);
      bus_wr(3'd7, 8'h55);
      bus_rd(3'd7, d, oe);
      check({tag, "_status_oe"}, int'(oe), 1);
      check({tag, "_status_data"}, int'(d), 1);
      @(negedge clk);
      check({tag, "_status_oe_drop"}, int'(bif.BUS_DATA_OE), 0);
    end
    for (int i = 0; i < 5000 && irq_total == irq0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    check({tag, "_done_irq"}, irq_total - irq0, 1);

    weff = (x >= 320) ? 0 : ((w < 320 - x) ? w : 320 - x);
    heff = (y >= 240) ? 0 : ((h < 240 - y) ? h : 240 - y);
    c  = mode[0];
    xr = mode[1];
    for (int yy = 0; yy < heff; yy++)
      for (int xx = 0; xx < weff; xx++) begin
        a = ((y + yy) << 9) | (x + xx);
        ref_mem[a] = xr ? (ref_mem[a] ^ c) : c;
        exp_q.push_back('{a, ref_mem[a], 0});
      end
    n = exp_q.size();

    nw = got_q.size() - base;
    first_addr = (nw > 0) ? int'(got_q[base].addr) : -1;
    check({tag, "_n_writes"}, nw, n);
    for (int i = 0; i < n && i < nw; i++) begin
      check($sformatf("%s_addr%0d", tag, i), int'(got_q[base + i].addr), int'(exp_q[i].addr));
      check($sformatf("%s_data%0d", tag, i), int'(got_q[base + i].data), int'(exp_q[i].data));
    end
    if (n > 0 && nw > 0)
      check({tag, "_first_we_latency"}, got_q[base].cyc - go_cyc, xr ? 3 : 2);
    exp_busy = (n == 0) ? 1 : (xr ? 1 + 2 * n : 1 + n);
    check({tag, "_busy_cycles"}, busy_total - busy0, exp_busy);
  endtask

  vec_t vecs[8];
  int   nw, fa, base, irq0, busy0, n0;
  logic [7:0] d;
  logic oe;

  initial begin
    vecs[0] = '{10, 5, 3, 2, 1, 6, 2570};
    vecs[1] = '{318, 239, 5, 4, 1, 2, 122686};
    vecs[2] = '{0, 0, 0, 5, 1, 0, -1};
    vecs[3] = '{320, 0, 5, 5, 1, 0, -1};
    vecs[4] = '{300, 230, 30, 30, 0, 200, 118060};
    vecs[5] = '{7, 239, 4, 0, 1, 0, -1};
    vecs[6] = '{5, 100, 511, 1, 1, 315, 51205};
    vecs[7] = '{12, 200, 3, 2, 3, 6, 102412};

    bif.BUS_ADDR = 8'h00;
    bif.BUS_DATA_IN = 8'h00;
    bif.BUS_WE = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_a_we", int'(bif.A_WE), 0);
    check("rst_a_addr", int'(bif.A_ADDR), 0);
    check("rst_a_data_in", int'(bif.A_DATA_IN), 0);
    check("rst_busy", int'(bif.BUSY), 0);
    check("rst_done_irq", int'(bif.DONE_IRQ), 0);
    check("rst_bus_oe", int'(bif.BUS_DATA_OE), 0);
    check("rst_bus_data", int'(bif.BUS_DATA_OUT), 0);
    rst_n = 1'b1;

    bus_rd(3'd7, d, oe);
    check("idle_status_oe", int'(oe), 1);
    check("idle_status_data", int'(d), 0);

    foreach (vecs[i]) begin
      run_rect(vecs[i].x, vecs[i].y, vecs[i].w, vecs[i].h, vecs[i].mode, 1'b0,
               $sformatf("vec%0d", i), nw, fa);
      check($sformatf("vec%0d_count_const", i), nw, vecs[i].n);
      check($sformatf("vec%0d_first_addr_const", i), fa, vecs[i].first_addr);
    end

    // XOR corner: preset (0,0)=1, (1,0)=0, then XOR colour 1 across both.
    run_rect(0, 0, 1, 1, 1, 1'b0, "preset0", nw, fa);
    run_rect(1, 0, 1, 1, 0, 1'b0, "preset1", nw, fa);
    base = got_q.size();
    run_rect(0, 0, 2, 1, 3, 1'b0, "xor2", nw, fa);
    if (got_q.size() >= base + 2) begin
      check("xor2_val0", int'(got_q[base].data), 0);
      check("xor2_val1", int'(got_q[base + 1].data), 1);
      check("xor2_span", got_q[base + 1].cyc - got_q[base].cyc + 2, 4);
    end else
      check("xor2_write_count", got_q.size() - base, 2);

    run_rect(0, 0, 100, 10, 1, 1'b1, "busy_ignore", nw, fa);

    for (int k = 0; k < 25; k++)
      run_rect($urandom_range(330, 0), $urandom_range(250, 0), $urandom_range(30, 0),
               $urandom_range(12, 0), $urandom_range(3, 0), 1'b0,
               $sformatf("rnd%0d", k), nw, fa);

    // Abort mid-fill with reset.
    program_rect(0, 0, 200, 5, 1);
    base = got_q.size();
    irq0 = irq_total;
    bus_wr(3'd7, 8'h00);
    for (int i = 0; i < 1000 && got_q.size() < base + 20; i++) @(negedge clk);
    check("abort_started", (got_q.size() >= base + 20) ? 1 : 0, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_a_we", int'(bif.A_WE), 0);
    check("abort_busy", int'(bif.BUSY), 0);
    check("abort_a_addr", int'(bif.A_ADDR), 0);
    check("abort_done_irq", int'(bif.DONE_IRQ), 0);
    n0 = got_q.size();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("abort_no_more_writes", got_q.size(), n0);
    check("abort_no_irq", irq_total - irq0, 0);

    // Registers are cleared by reset, so a bare GO is an empty rectangle.
    base  = got_q.size();
    irq0  = irq_total;
    busy0 = busy_total;
    bus_wr(3'd7, 8'h00);
    for (int i = 0; i < 100 && irq_total == irq0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("cleared_go_irq", irq_total - irq0, 1);
    check("cleared_go_writes", got_q.size() - base, 0);
    check("cleared_go_busy", busy_total - busy0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
